hour_counter: RTL and testbench

Hour stage of the clock chain. Consumes the minute stage's `min_carry` level and advances a 0–23 hour count once per minute wrap. Supports manual hour setting and produces registered BCD display digits in 12 h or 24 h format, plus a PM flag and a one-cycle `day_carry` pulse for a downstream day/date stage.

---
 rtl/hour_counter.sv | 106 ++++++++++
 tb/tb_hour_counter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hour_counter.sv
// Hour stage of the clock chain: 0-23 count advanced by minute wraps or manual set,
// with registered 12 h / 24 h BCD display digits, PM flag and a day-wrap pulse.
module hour_counter #(
    parameter int RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       min_carry,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic       set_inc,
    input  logic       set_dec,
    output logic [4:0] hour,
    output logic [1:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic       pm,
    output logic       day_carry
);

    localparam logic [4:0] RESET_VAL = 5'(RESET_HOUR);
    localparam logic [4:0] MAX_HOUR  = 5'd23;

    logic       mc_q, inc_q, dec_q;
    logic       mc_rise, inc_rise, dec_rise;
    logic [4:0] hour_reg, hour_next;
    logic       day_carry_reg, day_carry_next;
    logic [1:0] disp_tens_reg, disp_tens_next;
    logic [3:0] disp_ones_reg, disp_ones_next;
    logic       pm_reg, pm_next;
    logic [4:0] disp_val;

    // History flops reset high so levels already present at reset release never step.
    assign mc_rise  = min_carry & ~mc_q;
    assign inc_rise = set_inc   & ~inc_q;
    assign dec_rise = set_dec   & ~dec_q;

    always_comb begin
        hour_next      = hour_reg;
        day_carry_next = 1'b0;
        if (!set_en) begin
            if (mc_rise) begin
                if (hour_reg == MAX_HOUR) begin
                    hour_next      = 5'd0;
                    day_carry_next = 1'b1;
                end else begin
                    hour_next = hour_reg + 5'd1;
                end
            end
        end else if (inc_rise && !dec_rise) begin
            hour_next = (hour_reg == MAX_HOUR) ? 5'd0 : hour_reg + 5'd1;
        end else if (dec_rise && !inc_rise) begin
            hour_next = (hour_reg == 5'd0) ? MAX_HOUR : hour_reg - 5'd1;
        end
    end

    always_comb begin
        disp_val = hour_reg;
        if (mode_12h) begin
            if (hour_reg == 5'd0) begin
                disp_val = 5'd12;
            end else if (hour_reg > 5'd12) begin
                disp_val = hour_reg - 5'd12;
            end
        end
        if (disp_val >= 5'd20) begin
            disp_tens_next = 2'd2;
            disp_ones_next = 4'(disp_val - 5'd20);
        end else if (disp_val >= 5'd10) begin
            disp_tens_next = 2'd1;
            disp_ones_next = 4'(disp_val - 5'd10);
        end else begin
            disp_tens_next = 2'd0;
            disp_ones_next = 4'(disp_val);
        end
        pm_next = (hour_reg >= 5'd12);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mc_q          <= 1'b1;
            inc_q         <= 1'b1;
            dec_q         <= 1'b1;
            hour_reg      <= RESET_VAL;
            day_carry_reg <= 1'b0;
            disp_tens_reg <= 2'd0;
            disp_ones_reg <= 4'd0;
            pm_reg        <= 1'b0;
        end else begin
            mc_q          <= min_carry;
            inc_q         <= set_inc;
            dec_q         <= set_dec;
            hour_reg      <= hour_next;
            day_carry_reg <= day_carry_next;
            disp_tens_reg <= disp_tens_next;
            disp_ones_reg <= disp_ones_next;
            pm_reg        <= pm_next;
        end
    end

    assign hour      = hour_reg;
    assign day_carry = day_carry_reg;
    assign disp_tens = disp_tens_reg;
    assign disp_ones = disp_ones_reg;
    assign pm        = pm_reg;

endmodule

// File: tb/tb_hour_counter.sv
// Self-checking bench for hour_counter: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the hour rules.
module tb_hour_counter;

    localparam int TB_RESET_HOUR = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       min_carry = 1'b1;
    logic       mode_12h = 1'b0;
    logic       set_en = 1'b0;
    logic       set_inc = 1'b0;
    logic       set_dec = 1'b0;
    logic [4:0] hour;
    logic [1:0] disp_tens;
    logic [3:0] disp_ones;
    logic       pm;
    logic       day_carry;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_hour = TB_RESET_HOUR;
    int m_dc = 0, m_tens = 0, m_ones = 0, m_pm = 0;
    int m_prev_mc = 1, m_prev_inc = 1, m_prev_dec = 1;

    hour_counter #(.RESET_HOUR(TB_RESET_HOUR)) dut (
        .clk(clk), .reset(reset), .min_carry(min_carry), .mode_12h(mode_12h),
        .set_en(set_en), .set_inc(set_inc), .set_dec(set_dec), .hour(hour),
        .disp_tens(disp_tens), .disp_ones(disp_ones), .pm(pm), .day_carry(day_carry)
    );

    always #5 clk = ~clk;

    function automatic int shown(input int h, input logic m12);
        if (!m12) return h;
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    // Advance the model with the inputs present at the coming edge, then take the edge.
    task automatic tick();
        int d;
        bit r_mc, r_inc, r_dec;
        if (!reset) begin
            m_hour = TB_RESET_HOUR; m_dc = 0; m_tens = 0; m_ones = 0; m_pm = 0;
            m_prev_mc = 1; m_prev_inc = 1; m_prev_dec = 1;
        end else begin
            d = shown(m_hour, mode_12h);
            m_tens = d / 10; m_ones = d % 10; m_pm = (m_hour >= 12);
            r_mc  = min_carry && (m_prev_mc == 0);
            r_inc = set_inc && (m_prev_inc == 0);
            r_dec = set_dec && (m_prev_dec == 0);
            m_dc = 0;
            if (!set_en) begin
                if (r_mc) begin
                    m_dc = (m_hour == 23);
                    m_hour = (m_hour + 1) % 24;
                end
            end else if (r_inc && !r_dec) m_hour = (m_hour + 1) % 24;
            else if (r_dec && !r_inc) m_hour = (m_hour + 23) % 24;
            m_prev_mc = min_carry; m_prev_inc = set_inc; m_prev_dec = set_dec;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; min_carry = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (hour !== 5'(TB_RESET_HOUR) || day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: hour=%0d dc=%0b expected hour=%0d dc=0", hour, day_carry, TB_RESET_HOUR);
        end
        vectors++;
        if (disp_tens !== 2'd0 || disp_ones !== 4'd0 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_disp: disp=%0d%0d pm=%0b expected 00 pm=0", disp_tens, disp_ones, pm);
        end
        repeat (2) tick();
        vectors++;
        if (hour !== 5'd0) begin
            miscompares++;
            $display("FAIL held_carry_no_step: hour=%0d expected 0", hour);
        end
        min_carry = 1'b0; tick();
        min_carry = 1'b1; tick();
        vectors++;
        if (hour !== 5'd1) begin
            miscompares++;
            $display("FAIL first_step: hour=%0d expected 1", hour);
        end
        tick();
        vectors++;
        if (disp_tens !== 2'd0 || disp_ones !== 4'd1) begin
            miscompares++;
            $display("FAIL first_disp: disp=%0d%0d expected 01", disp_tens, disp_ones);
        end
        // restore hour 0 for the following tests
        set_en = 1'b1; set_dec = 1'b1; tick();
        set_dec = 1'b0; set_en = 1'b0; tick();
    endtask

    task automatic test_day_wrap();
        set_en = 1'b1; set_dec = 1'b1; tick();
        vectors++;
        if (hour !== 5'd23 || day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL set_dec_wrap: hour=%0d dc=%0b expected hour=23 dc=0", hour, day_carry);
        end
        set_dec = 1'b0; set_en = 1'b0; min_carry = 1'b0; tick();
        mode_12h = 1'b1; min_carry = 1'b1; tick();
        vectors++;
        if (hour !== 5'd0 || day_carry !== 1'b1) begin
            miscompares++;
            $display("FAIL day_wrap: hour=%0d dc=%0b expected hour=0 dc=1", hour, day_carry);
        end
        tick();
        vectors++;
        if (day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL day_carry_width: dc=%0b expected 0", day_carry);
        end
        vectors++;
        if (disp_tens !== 2'd1 || disp_ones !== 4'd2 || pm !== 1'b0) begin
            miscompares++;
            $display("FAIL midnight_12h: disp=%0d%0d pm=%0b expected 12 pm=0", disp_tens, disp_ones, pm);
        end
    endtask

    task automatic test_sweep_12h();
        int exp_d;
        mode_12h = 1'b1;
        for (int i = 0; i < 24; i++) begin
            min_carry = 1'b0; tick();
            exp_d = (i % 12 == 0) ? 12 : i % 12;
            vectors++;
            if (hour !== 5'(i) || disp_tens * 10 + disp_ones != exp_d || pm !== (i >= 12) || disp_tens > 2'd1) begin
                miscompares++;
                $display("FAIL sweep_12h: hour=%0d disp=%0d%0d pm=%0b expected hour=%0d disp=%0d pm=%0b",
                         hour, disp_tens, disp_ones, pm, i, exp_d, i >= 12);
            end
            min_carry = 1'b1; tick();
        end
    endtask

    task automatic test_set_mode();
        set_en = 1'b1;
        set_dec = 1'b1; tick(); set_dec = 1'b0; tick();
        set_dec = 1'b1; tick(); set_dec = 1'b0; tick();
        vectors++;
        if (hour !== 5'd22 || day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL set_dec_twice: hour=%0d dc=%0b expected hour=22 dc=0", hour, day_carry);
        end
        set_inc = 1'b1;
        repeat (10) tick();
        vectors++;
        if (hour !== 5'd23) begin
            miscompares++;
            $display("FAIL held_inc: hour=%0d expected 23", hour);
        end
        set_inc = 1'b0; tick();
        set_inc = 1'b1; set_dec = 1'b1; tick();
        vectors++;
        if (hour !== 5'd23) begin
            miscompares++;
            $display("FAIL inc_dec_together: hour=%0d expected 23", hour);
        end
        set_inc = 1'b0; set_dec = 1'b0; tick();
    endtask

    task automatic test_mc_ignored_in_set();
        set_en = 1'b1; min_carry = 1'b0; tick();
        min_carry = 1'b1; tick();
        set_en = 1'b0; tick(); tick();
        vectors++;
        if (hour !== 5'd23 || day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL mc_in_set: hour=%0d dc=%0b expected hour=23 dc=0", hour, day_carry);
        end
    endtask

    task automatic test_reset_mid();
        min_carry = 1'b0; tick();
        min_carry = 1'b1; reset = 1'b0; tick();
        vectors++;
        if (hour !== 5'(TB_RESET_HOUR) || day_carry !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: hour=%0d dc=%0b expected hour=%0d dc=0", hour, day_carry, TB_RESET_HOUR);
        end
        reset = 1'b1; tick();
        vectors++;
        if (day_carry !== 1'b0 || hour !== 5'(TB_RESET_HOUR)) begin
            miscompares++;
            $display("FAIL reset_mid_after: hour=%0d dc=%0b expected hour=%0d dc=0", hour, day_carry, TB_RESET_HOUR);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) min_carry = ~min_carry;
            if ($urandom_range(0, 15) == 0) set_en = ~set_en;
            if ($urandom_range(0, 7) == 0) mode_12h = ~mode_12h;
            set_inc = ($urandom_range(0, 2) == 0);
            set_dec = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 79) != 0);
            tick();
            vectors++;
            if (hour !== 5'(m_hour) || day_carry !== 1'(m_dc) || disp_tens !== 2'(m_tens) ||
                disp_ones !== 4'(m_ones) || pm !== 1'(m_pm)) begin
                miscompares++;
                $display("FAIL random[%0d]: hour=%0d dc=%0b disp=%0d%0d pm=%0b expected hour=%0d dc=%0d disp=%0d%0d pm=%0d",
                         n, hour, day_carry, disp_tens, disp_ones, pm, m_hour, m_dc, m_tens, m_ones, m_pm);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_day_wrap();
        test_sweep_12h();
        test_set_mode();
        test_mc_ignored_in_set();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
